// File: rtl/periodic_force_pkg.sv
// Shared types and default constants for the periodic force controller.
package periodic_force_pkg;

  typedef enum logic {
    StNormal = 1'b0,
    StForced = 1'b1
  } state_e;

  localparam int unsigned DefaultPeriod   = 10;
  localparam logic [3:0]  DefaultForceVal = 4'h5;

endpackage

// File: rtl/period_counter.sv
// Free-running modulo-PERIOD counter with a terminal-count strobe and a registered tick pulse.
module period_counter
  import periodic_force_pkg::*;
#(
  parameter int unsigned PERIOD = DefaultPeriod
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_next,
  output logic tick
);

  localparam int unsigned CntW = $clog2(PERIOD);

  logic [CntW-1:0] cnt_q;

  assign tick_next = (cnt_q == CntW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (tick_next) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/periodic_force_ctrl.sv
// Register with periodic force/release behaviour: a tick forces q to FORCE_VAL until released,
// and a release leaves the forced value in the register until the next load.
module periodic_force_ctrl
  import periodic_force_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      PERIOD    = DefaultPeriod,
  parameter logic [WIDTH-1:0] FORCE_VAL = WIDTH'(DefaultForceVal),
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             force_en,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             release_req,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic             tick,
  output logic [CNT_W-1:0] force_cnt
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_next;

  period_counter #(
    .PERIOD(PERIOD)
  ) u_period_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_next(tick_next),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StNormal;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StNormal: begin
          if (load) data_q <= d_in;
          if (tick_next && force_en) begin
            state_q <= StForced;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StForced: begin
          // Release hands the forced value to the register; a coincident load overrides it.
          if (release_req) begin
            state_q <= StNormal;
            data_q  <= load ? d_in : FORCE_VAL;
          end
        end
        default: state_q <= StNormal;
      endcase
    end
  end

  assign forced    = (state_q == StForced);
  assign q         = forced ? FORCE_VAL : data_q;
  assign force_cnt = cnt_q;

endmodule

// File: tb/tb_periodic_force_ctrl.sv
// Scoreboard bench: the stimulus side predicts each cycle's outputs from a force/release model,
// a negedge monitor pops and compares them against two instances (8-bit and 2-bit event counters).
module tb_periodic_force_ctrl;

  localparam int unsigned Period = 10;
  localparam logic [3:0]  Fv     = 4'h5;

  typedef struct {
    logic [3:0] q;
    logic       forced;
    logic       tick;
    logic [7:0] fc8;
    logic [1:0] fc2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d_in = '0;
  logic       release_req = 1'b0;

  logic [3:0] q_a, q_b;
  logic       forced_a, forced_b, tick_a, tick_b;
  logic [7:0] fc_a;
  logic [1:0] fc_b;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state
  int         m_edges = 0;
  bit         m_forced = 0;
  logic [3:0] m_data = '0;
  int         m_entries = 0;
  bit         m_tick = 0;

  always #5 clk = ~clk;

  periodic_force_ctrl #(
    .WIDTH(4), .PERIOD(Period), .FORCE_VAL(Fv), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .force_en(force_en), .load(load), .d_in(d_in),
    .release_req(release_req), .q(q_a), .forced(forced_a), .tick(tick_a), .force_cnt(fc_a)
  );

  periodic_force_ctrl #(
    .WIDTH(4), .PERIOD(Period), .FORCE_VAL(Fv), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .force_en(force_en), .load(load), .d_in(d_in),
    .release_req(release_req), .q(q_b), .forced(forced_b), .tick(tick_b), .force_cnt(fc_b)
  );

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q", int'(q_a), int'(e.q));
      check("forced", int'(forced_a), int'(e.forced));
      check("tick", int'(tick_a), int'(e.tick));
      check("force_cnt", int'(fc_a), int'(e.fc8));
      check("q_sat", int'(q_b), int'(e.q));
      check("forced_sat", int'(forced_b), int'(e.forced));
      check("tick_sat", int'(tick_b), int'(e.tick));
      check("force_cnt_sat", int'(fc_b), int'(e.fc2));
    end
  end

  // Drive one cycle of inputs, advance the model across the coming edge and queue the result.
  task automatic step(input bit r, input bit fe, input bit ld, input logic [3:0] d,
                      input bit rel);
    exp_t e;
    rst_n       = r;
    force_en    = fe;
    load        = ld;
    d_in        = d;
    release_req = rel;
    if (!r) begin
      m_edges   = 0;
      m_forced  = 0;
      m_data    = '0;
      m_entries = 0;
      m_tick    = 0;
    end else begin
      m_edges++;
      m_tick = (m_edges % Period) == 0;
      if (!m_forced) begin
        if (ld) m_data = d;
        if (m_tick && fe) begin
          m_forced = 1;
          m_entries++;
        end
      end else if (rel) begin
        m_forced = 0;
        m_data   = ld ? d : Fv;
      end
    end
    e.q      = m_forced ? Fv : m_data;
    e.forced = m_forced;
    e.tick   = m_tick;
    e.fc8    = (m_entries > 255) ? 8'hff : 8'(m_entries);
    e.fc2    = (m_entries > 3) ? 2'h3 : 2'(m_entries);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_forced(input int max_cycles);
    int n = 0;
    while (!m_forced && n < max_cycles) begin
      step(1, 1, 0, 4'h0, 0);
      n++;
    end
    if (!m_forced) begin
      n_checks++;
      n_fail++;
      $display("FAIL force_timeout: got forced=0 after %0d cycles, expected forced=1", n);
    end
  endtask

  initial begin
    // 1: reset, then forcing enabled with no loads
    step(0, 0, 0, 4'h0, 0);
    step(0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 4'h0, 0);

    // 2: load A at cycle 3, forced at the tick, load C while forced is ignored
    step(0, 0, 0, 4'h0, 0);
    for (int i = 1; i <= 12; i++) step(1, 1, i == 3, 4'hA, 0);
    step(1, 1, 1, 4'hC, 0);
    step(1, 1, 0, 4'h0, 0);

    // 3: release alone keeps FORCE_VAL, then a load of 3
    step(1, 0, 0, 4'h0, 1);
    step(1, 0, 1, 4'h3, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h0, 0);

    // 4: release with load in the same cycle, re-forced at the next tick
    run_until_forced(3 * Period);
    step(1, 1, 1, 4'h9, 1);
    run_until_forced(3 * Period);

    // 5: stay forced across three ticks, then repeated release/force to saturate CNT_W=2
    for (int i = 0; i < 3 * Period; i++) step(1, i % 2 == 0, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'h0, 1);
      run_until_forced(3 * Period);
    end

    // 6: reset while forced with data 7, counter restarts
    step(1, 1, 0, 4'h0, 1);
    step(1, 1, 1, 4'h7, 0);
    run_until_forced(3 * Period);
    step(0, 1, 1, 4'hE, 1);
    for (int i = 0; i < Period + 3; i++) step(1, 1, 0, 4'h0, 0);

    // Random phase
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 3, 4'($urandom), $urandom_range(0, 99) < 12);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
